mips_mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS CPU.
- Sequences the shared datapath (PC, IR, GRF, ALU, DM, EXT and the 2-way/3-way MUXes) through the states IF/ID/EX/MEM/WB.
- Decodes the 6-bit opcode and funct fields of the current IR and drives every write enable and MUX select.
- Handles a DM ready handshake and pulses `instr_done` once per retired instruction.

---
 rtl/mips_mc_ctrl_pkg.sv | 61 ++++++
 rtl/mips_mc_ctrl_decode.sv | 32 +++
 rtl/mips_mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and datapath MUXes.
// Opcodes, funct codes, FSM states, select constants and class vector indices.
package mips_mc_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic       B_RT    = 1'b0;
    localparam logic       B_EXT   = 1'b1;
    localparam logic       EXT_ZERO = 1'b0;
    localparam logic       EXT_SIGN = 1'b1;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_31 = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DM   = 2'd1;
    localparam logic [1:0] WD_PC   = 2'd2;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_RS  = 2'd3;

    // Bit positions in the one-hot instruction class vector.
    localparam int CLS_ADDU = 0;
    localparam int CLS_SUBU = 1;
    localparam int CLS_JR   = 2;
    localparam int CLS_ORI  = 3;
    localparam int CLS_LUI  = 4;
    localparam int CLS_LW   = 5;
    localparam int CLS_SW   = 6;
    localparam int CLS_BEQ  = 7;
    localparam int CLS_JAL  = 8;
    localparam int CLS_NOP  = 9;
    localparam int N_CLS    = 10;

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational op/funct decoder producing a one-hot instruction class.
// Anything not recognised (sll, illegal encodings) lands in the NOP class.
module mips_decode
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [N_CLS-1:0] cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: cls[CLS_SUBU] = 1'b1;
                    FN_JR:   cls[CLS_JR]   = 1'b1;
                    default: cls[CLS_NOP]  = 1'b1;
                endcase
            end
            OP_ORI:  cls[CLS_ORI] = 1'b1;
            OP_LUI:  cls[CLS_LUI] = 1'b1;
            OP_LW:   cls[CLS_LW]  = 1'b1;
            OP_SW:   cls[CLS_SW]  = 1'b1;
            OP_BEQ:  cls[CLS_BEQ] = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls[CLS_NOP] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: IF/ID/EX/MEM/WB sequencing with Mealy
// outputs decoded from state, instruction class, zero and dm_ready.
//
//   state | meaning
//   IF    | fetch: load IR, PC <= PC+4
//   ID    | decode; NOP retires here, JAL skips to WB
//   EX    | ALU operation; BEQ/JR retire here
//   MEM   | DM access, held while dm_ready is low
//   WB    | GRF write (JAL also redirects PC)
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter bit USE_DM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       dm_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       rf_we,
    output logic       dm_we,
    output logic       dm_re,
    output logic [1:0] alu_op,
    output logic       alu_b_sel,
    output logic       ext_op,
    output logic [1:0] reg_dst_sel,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_sel,
    output logic [2:0] state,
    output logic       instr_done
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [N_CLS-1:0] w_cls;
    logic             w_rtype;
    logic             w_dm_ok;

    mips_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (w_cls)
    );

    assign w_rtype = w_cls[CLS_ADDU] | w_cls[CLS_SUBU];
    assign w_dm_ok = !USE_DM_READY || dm_ready;
    assign state   = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IF;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        dm_we       = 1'b0;
        dm_re       = 1'b0;
        alu_op      = ALU_ADD;
        alu_b_sel   = B_RT;
        ext_op      = EXT_ZERO;
        reg_dst_sel = RDST_RT;
        wd_sel      = WD_ALU;
        npc_sel     = NPC_PC4;
        instr_done  = 1'b0;
        // Reset overrides everything so no partial write escapes mid-instruction.
        if (!reset) begin
            case (r_state)
                ST_IF: begin
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    npc_sel     = NPC_PC4;
                    w_state_nxt = ST_ID;
                end
                ST_ID: begin
                    if (w_cls[CLS_JAL]) begin
                        w_state_nxt = ST_WB;
                    end else if (w_cls[CLS_NOP]) begin
                        instr_done  = 1'b1;
                        w_state_nxt = ST_IF;
                    end else begin
                        w_state_nxt = ST_EX;
                    end
                end
                ST_EX: begin
                    if (w_rtype) begin
                        alu_b_sel   = B_RT;
                        alu_op      = w_cls[CLS_SUBU] ? ALU_SUB : ALU_ADD;
                        w_state_nxt = ST_WB;
                    end else if (w_cls[CLS_ORI]) begin
                        alu_b_sel   = B_EXT;
                        ext_op      = EXT_ZERO;
                        alu_op      = ALU_OR;
                        w_state_nxt = ST_WB;
                    end else if (w_cls[CLS_LUI]) begin
                        alu_b_sel   = B_EXT;
                        alu_op      = ALU_LUI;
                        w_state_nxt = ST_WB;
                    end else if (w_cls[CLS_LW] || w_cls[CLS_SW]) begin
                        alu_b_sel   = B_EXT;
                        ext_op      = EXT_SIGN;
                        alu_op      = ALU_ADD;
                        w_state_nxt = ST_MEM;
                    end else if (w_cls[CLS_BEQ]) begin
                        alu_b_sel   = B_RT;
                        alu_op      = ALU_SUB;
                        pc_we       = zero;
                        npc_sel     = NPC_BR;
                        instr_done  = 1'b1;
                        w_state_nxt = ST_IF;
                    end else if (w_cls[CLS_JR]) begin
                        pc_we       = 1'b1;
                        npc_sel     = NPC_RS;
                        instr_done  = 1'b1;
                        w_state_nxt = ST_IF;
                    end
                end
                ST_MEM: begin
                    dm_re = w_cls[CLS_LW];
                    dm_we = w_cls[CLS_SW];
                    if (!w_dm_ok) begin
                        w_state_nxt = ST_MEM;
                    end else if (w_cls[CLS_LW]) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        instr_done  = 1'b1;
                        w_state_nxt = ST_IF;
                    end
                end
                ST_WB: begin
                    rf_we       = 1'b1;
                    instr_done  = 1'b1;
                    w_state_nxt = ST_IF;
                    if (w_cls[CLS_JAL]) begin
                        reg_dst_sel = RDST_31;
                        wd_sel      = WD_PC;
                        pc_we       = 1'b1;
                        npc_sel     = NPC_J;
                    end else if (w_rtype) begin
                        reg_dst_sel = RDST_RD;
                        wd_sel      = WD_ALU;
                    end else if (w_cls[CLS_LW]) begin
                        reg_dst_sel = RDST_RT;
                        wd_sel      = WD_DM;
                    end
                end
                default: w_state_nxt = ST_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected outputs are queued
// from an instruction-level trace model and compared with a care mask.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic       ir_we;
        logic       rf_we;
        logic       dm_we;
        logic       dm_re;
        logic       done;
        logic [1:0] alu_op;
        logic       b_sel;
        logic       ext_op;
        logic [1:0] rdst;
        logic [1:0] wd;
        logic [1:0] npc;
    } obs_t;

    localparam int OW = $bits(obs_t);

    typedef struct {
        obs_t       val;
        obs_t       care;
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       dmr;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h23;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       dm_ready = 1'b0;
    logic       pc_we, ir_we, rf_we, dm_we, dm_re, alu_b_sel, ext_op, instr_done;
    logic [1:0] alu_op, reg_dst_sel, wd_sel, npc_sel;
    logic [2:0] state;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.USE_DM_READY(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .dm_ready    (dm_ready),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .dm_we       (dm_we),
        .dm_re       (dm_re),
        .alu_op      (alu_op),
        .alu_b_sel   (alu_b_sel),
        .ext_op      (ext_op),
        .reg_dst_sel (reg_dst_sel),
        .wd_sel      (wd_sel),
        .npc_sel     (npc_sel),
        .state       (state),
        .instr_done  (instr_done)
    );

    function automatic exp_t base(string nm, logic [5:0] op_i, logic [5:0] fn_i, logic [2:0] st);
        exp_t e;
        e.val        = '0;
        e.care       = '0;
        e.val.st     = st;
        e.care.st    = 3'h7;
        e.care.pc_we = 1'b1;
        e.care.ir_we = 1'b1;
        e.care.rf_we = 1'b1;
        e.care.dm_we = 1'b1;
        e.care.dm_re = 1'b1;
        e.care.done  = 1'b1;
        e.rst        = 1'b0;
        e.op         = op_i;
        e.funct      = fn_i;
        e.zero       = 1'($urandom_range(0, 1));
        e.dmr        = 1'($urandom_range(0, 1));
        e.name       = nm;
        return e;
    endfunction

    // Expected per-cycle trace of one instruction; waits = DM cycles with dm_ready low.
    task automatic push_instr(input string nm, input logic [5:0] op_i, input logic [5:0] fn_i,
                              input logic z, input int waits);
        exp_t e;
        logic is_add, is_sub, is_r, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_nop;
        is_add = (op_i == 6'h00) && (fn_i == 6'h21);
        is_sub = (op_i == 6'h00) && (fn_i == 6'h23);
        is_jr  = (op_i == 6'h00) && (fn_i == 6'h08);
        is_r   = is_add || is_sub;
        is_ori = (op_i == 6'h0D);
        is_lui = (op_i == 6'h0F);
        is_lw  = (op_i == 6'h23);
        is_sw  = (op_i == 6'h2B);
        is_beq = (op_i == 6'h04);
        is_jal = (op_i == 6'h03);
        is_nop = !(is_r || is_jr || is_ori || is_lui || is_lw || is_sw || is_beq || is_jal);

        e = base({nm, ".IF"}, op_i, fn_i, 3'd0);
        e.val.pc_we = 1'b1; e.val.ir_we = 1'b1; e.care.npc = 2'b11; e.val.npc = 2'd0;
        q.push_back(e);

        e = base({nm, ".ID"}, op_i, fn_i, 3'd1);
        e.val.done = is_nop;
        q.push_back(e);
        if (is_nop) return;

        if (is_jal) begin
            e = base({nm, ".WB"}, op_i, fn_i, 3'd4);
            e.val.rf_we = 1'b1; e.val.pc_we = 1'b1; e.val.done = 1'b1;
            e.val.rdst = 2'd2; e.val.wd = 2'd2; e.val.npc = 2'd2;
            e.care.rdst = 2'b11; e.care.wd = 2'b11; e.care.npc = 2'b11;
            q.push_back(e);
            return;
        end

        e = base({nm, ".EX"}, op_i, fn_i, 3'd2);
        if (!is_jr) begin
            e.care.alu_op = 2'b11; e.care.b_sel = 1'b1;
        end
        if (is_r) begin
            e.val.alu_op = is_sub ? 2'd1 : 2'd0; e.val.b_sel = 1'b0;
        end else if (is_ori) begin
            e.val.alu_op = 2'd2; e.val.b_sel = 1'b1; e.val.ext_op = 1'b0; e.care.ext_op = 1'b1;
        end else if (is_lui) begin
            e.val.alu_op = 2'd3; e.val.b_sel = 1'b1;
        end else if (is_lw || is_sw) begin
            e.val.alu_op = 2'd0; e.val.b_sel = 1'b1; e.val.ext_op = 1'b1; e.care.ext_op = 1'b1;
        end else if (is_beq) begin
            e.val.alu_op = 2'd1; e.val.b_sel = 1'b0;
            e.zero = z; e.val.pc_we = z; e.val.done = 1'b1;
            e.val.npc = 2'd1; e.care.npc = z ? 2'b11 : 2'b00;
        end else begin
            e.val.pc_we = 1'b1; e.val.done = 1'b1; e.val.npc = 2'd3; e.care.npc = 2'b11;
        end
        q.push_back(e);
        if (is_beq || is_jr) return;

        if (is_lw || is_sw) begin
            for (int i = 0; i <= waits; i++) begin
                e = base({nm, ".MEM"}, op_i, fn_i, 3'd3);
                e.dmr = (i == waits);
                e.val.dm_re = is_lw; e.val.dm_we = is_sw;
                e.val.done = is_sw && (i == waits);
                q.push_back(e);
            end
            if (is_sw) return;
        end

        e = base({nm, ".WB"}, op_i, fn_i, 3'd4);
        e.val.rf_we = 1'b1; e.val.done = 1'b1;
        e.care.rdst = 2'b11; e.care.wd = 2'b11;
        e.val.rdst = is_r ? 2'd1 : 2'd0;
        e.val.wd = is_lw ? 2'd1 : 2'd0;
        q.push_back(e);
    endtask

    task automatic drive_cycle(input exp_t e, output obs_t o);
        reset = e.rst; op = e.op; funct = e.funct; zero = e.zero; dm_ready = e.dmr;
        @(negedge clk);
        o = '{st: state, pc_we: pc_we, ir_we: ir_we, rf_we: rf_we, dm_we: dm_we, dm_re: dm_re,
              done: instr_done, alu_op: alu_op, b_sel: alu_b_sel, ext_op: ext_op,
              rdst: reg_dst_sel, wd: wd_sel, npc: npc_sel};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        for (int i = 0; i < 3; i++) begin
            e = base("reset", 6'h23, 6'h00, 3'd0);
            e.rst = 1'b1;
            e.care = '1;
            q.push_back(e);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_alu_ops();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        push_instr("addu", 6'h00, 6'h21, 1'b0, 0);
        push_instr("subu", 6'h00, 6'h23, 1'b0, 0);
        push_instr("ori",  6'h0D, 6'h15, 1'b0, 0);
        push_instr("lui",  6'h0F, 6'h23, 1'b0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_mem();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        push_instr("lw_w2", 6'h23, 6'h00, 1'b0, 2);
        push_instr("sw_w0", 6'h2B, 6'h00, 1'b0, 0);
        push_instr("lw_w0", 6'h23, 6'h3F, 1'b1, 0);
        push_instr("sw_w1", 6'h2B, 6'h08, 1'b1, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_branch_jump();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        push_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0);
        push_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0);
        push_instr("jal",    6'h03, 6'h00, 1'b0, 0);
        push_instr("jr",     6'h00, 6'h08, 1'b0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_nop();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        push_instr("illegal", 6'h3F, 6'h21, 1'b0, 0);
        push_instr("sll",     6'h00, 6'h00, 1'b0, 0);
        push_instr("addiu",   6'h09, 6'h08, 1'b1, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_in_mem();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        push_instr("sw_rst", 6'h2B, 6'h00, 1'b0, 3);
        while (q.size() > 4) void'(q.pop_back());
        q[3].rst = 1'b1;
        q[3].dmr = 1'b0;
        q[3].val = '0;
        q[3].val.st = 3'd3;
        q[3].care = '1;
        q[3].name = "sw_rst.MEM_reset";
        push_instr("after_rst", 6'h00, 6'h21, 1'b0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        logic [OW-1:0] got, req, msk;
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03, 6'h3A};
        logic [5:0] fns[10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int i = 0; i < 16; i++) begin
            int k;
            k = $urandom_range(0, 9);
            push_instr($sformatf("b2b%0d", i), ops[k], fns[k], 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2));
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            drive_cycle(e, o);
            got = o; req = e.val; msk = e.care;
            n_checks++;
            if ((got & msk) !== (req & msk))
                $display("FAIL %s: got %h required %h (mask %h)", e.name, got & msk, req & msk, msk);
            else
                n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch_jump();
        test_nop();
        test_reset_in_mem();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
